// File: rtl/ece429_pkg.sv
// ece429_pkg: memory access encodings, word size and fetch defaults shared across the core
package ece429_pkg;
    localparam logic [1:0] ACCESS_WORD = 2'b00;
    localparam logic [1:0] ACCESS_4W = 2'b01;
    localparam logic [1:0] ACCESS_8W = 2'b10;
    localparam logic [1:0] ACCESS_16W = 2'b11;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO with flush and registered full/empty flags
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    logic [CW-1:0] count_next;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count_next;
            full <= count_next == CW'(DEPTH);
            empty <= count_next == '0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with one outstanding 1-cycle memory read,
// a small {pc, insn} buffer toward decode, and redirect that flushes and drops stale data.
module fetch_unit import ece429_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic        mem_busy,
    input  logic [31:0] mem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid
);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_state_t state, state_next;
    logic [31:0] fetch_pc;
    logic discard, accept, push, pop, buf_full, buf_empty;
    logic [CW-1:0] count, count_after;
    assign mem_access_size = ACCESS_WORD;
    assign mem_rw = 1'b0;
    assign mem_address = fetch_pc;
    assign mem_enable = state == S_REQ && !buf_full;
    assign accept = mem_enable && !mem_busy;
    assign push = state == S_WAIT && !discard && !redirect;
    assign pop = insn_valid && !stall && !redirect;
    assign insn_valid = !buf_empty;
    assign count_after = count + CW'(push) - CW'(pop);
    // A redirect never waits for the buffer: it is flushed on the same edge.
    always_comb begin
        state_next = (state == S_REQ || redirect) ? (accept ? S_WAIT : S_REQ)
                   : (count_after < CW'(DEPTH) ? S_REQ : S_IDLE);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            fetch_pc <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state <= state_next;
            discard <= redirect && accept;
            if (redirect) fetch_pc <= redirect_pc & ~32'h3;
            else if (accept) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
        end
    end
    // The response always belongs to the word just behind fetch_pc.
    fetch_buffer #(.WIDTH(64), .DEPTH(DEPTH)) u_buffer (
        .clock(clock),
        .reset(reset),
        .flush(redirect),
        .push(push),
        .pop(pop),
        .wdata({fetch_pc - 32'(WORD_BYTES), mem_data}),
        .rdata({insn_pc, insn}),
        .full(buf_full),
        .empty(buf_empty),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random stall/busy/redirect traffic against a stream-level model
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h8002_0000;
    logic clock, reset, mem_rw, mem_enable, mem_busy, stall, redirect, insn_valid;
    logic [31:0] mem_address, mem_data, redirect_pc, insn, insn_pc;
    logic [1:0] mem_access_size;
    int total = 0, bad = 0, pops = 0;
    typedef struct {logic [31:0] pc; logic [31:0] w;} exp_t;
    exp_t q[$];

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .mem_address(mem_address),
        .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
        .mem_busy(mem_busy), .mem_data(mem_data), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8002_0000: return 32'hAAAA_0001;
            32'h8002_0004: return 32'hBBBB_0002;
            32'h8002_0008: return 32'hCCCC_0003;
            32'h8002_000C: return 32'hDDDD_0004;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory: a request accepted on an edge is answered during the following cycle.
    initial begin
        logic acc;
        logic [31:0] addr;
        mem_data = 0;
        forever begin
            @(negedge clock);
            acc = mem_enable && !mem_busy;
            addr = mem_address;
            @(posedge clock);
            #1 mem_data = acc ? mem_word(addr) : $urandom();
        end
    end

    // Monitor: the delivered stream must be consecutive words from the last reset/redirect target.
    initial begin
        logic [31:0] next_pc = RESET_PC, prev_addr = 0;
        bit prev_reset = 0, prev_redirect = 0, prev_en = 0, prev_busy = 0, first_req = 0;
        int since = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                q.delete();
                next_pc = RESET_PC;
                prev_reset = 1;
                prev_redirect = 0;
                prev_en = 0;
                first_req = 1;
                since = 0;
                continue;
            end
            if (prev_reset) begin
                check("rst_valid", insn_valid, 0);
                check("rst_enable", mem_enable, 0);
                check("rst_insn", insn, 0);
                check("rst_insn_pc", insn_pc, 0);
            end
            if (first_req && mem_enable) begin
                check("first_req_addr", mem_address, RESET_PC);
                first_req = 0;
            end else if (first_req && ++since > 4) begin
                check("first_req_timeout", mem_enable, 1);
                first_req = 0;
            end
            while (q.size() < 4) begin
                q.push_back('{next_pc, mem_word(next_pc)});
                next_pc += 4;
            end
            if (prev_redirect) check("valid_after_redirect", insn_valid, 0);
            if (insn_valid) begin
                check("head_pc", insn_pc, q[0].pc);
                check("head_insn", insn, q[0].w);
            end
            if (redirect) begin
                q.delete();
                next_pc = redirect_pc & ~32'h3;
            end else if (insn_valid && !stall) begin
                void'(q.pop_front());
                pops++;
            end
            check("addr_align", {30'd0, mem_address[1:0]}, 0);
            check("access_const", {29'd0, mem_access_size, mem_rw}, 0);
            if (prev_en && prev_busy && !prev_redirect && !prev_reset) begin
                check("busy_hold_en", mem_enable, 1);
                check("busy_hold_addr", mem_address, prev_addr);
            end
            if (prev_en && !prev_busy && !prev_reset) check("one_in_flight", mem_enable, 0);
            prev_reset = 0;
            prev_redirect = redirect;
            prev_en = mem_enable;
            prev_busy = mem_busy;
            prev_addr = mem_address;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1;
        stall = 0;
        mem_busy = 0;
        redirect = 0;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic wait_accept(input string name);
        bit found = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clock);
            found = mem_enable && !mem_busy;
        end
        if (!found) check(name, found, 1);
    endtask

    initial begin
        bit found;
        int p0;
        reset = 1;
        stall = 0;
        mem_busy = 0;
        redirect = 0;
        redirect_pc = 0;
        #1;
        do_reset();
        // Stall from the start: buffer fills, requests stop, head stays at A.
        stall = 1;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clock);
            found = insn_valid;
        end
        check("stall_first_valid", found, 1);
        repeat (5) begin
            @(negedge clock);
            check("stall_insn_hold", insn, 32'hAAAA_0001);
            check("stall_valid_hold", insn_valid, 1);
        end
        check("stall_full_no_req", mem_enable, 0);
        @(posedge clock);
        #1 stall = 0;
        repeat (12) tick();
        // Free-running fetch from reset.
        do_reset();
        p0 = pops;
        repeat (20) tick();
        check("stream_progress", pops - p0 >= 4, 1);
        // Busy held for 3 cycles on the second request.
        do_reset();
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clock);
            found = mem_enable && !mem_busy && mem_address == RESET_PC;
        end
        check("busy_first_req", found, 1);
        @(posedge clock);
        #1 mem_busy = 1;
        @(negedge clock);
        repeat (3) begin
            @(negedge clock);
            check("busy_enable", mem_enable, 1);
            check("busy_addr", mem_address, 32'h8002_0004);
        end
        @(posedge clock);
        #1 mem_busy = 0;
        repeat (10) tick();
        // Redirect while a response is in flight.
        wait_accept("redir_accept_timeout");
        @(posedge clock);
        #1 redirect = 1;
        redirect_pc = 32'h8002_0103;
        tick();
        redirect = 0;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clock);
            found = insn_valid;
        end
        check("redir_target_pc", found ? insn_pc : 32'hDEAD_DEAD, 32'h8002_0100);
        // Address wrap at the top of memory.
        @(posedge clock);
        #1 redirect = 1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 0;
        found = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clock);
            found = mem_enable && mem_address == 32'h0;
        end
        check("wrap_to_zero", found, 1);
        repeat (6) tick();
        // One-cycle reset while a response is in flight.
        wait_accept("rst_wait_accept_timeout");
        @(posedge clock);
        #1 reset = 1;
        tick();
        reset = 0;
        repeat (20) tick();
        // Random traffic.
        p0 = pops;
        for (int c = 0; c < 3000; c++) begin
            stall = $urandom_range(0, 99) < 30;
            mem_busy = $urandom_range(0, 99) < 25;
            redirect = $urandom_range(0, 99) < 3;
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                      : (32'h8002_0000 + 32'($urandom_range(0, 255)));
            tick();
        end
        stall = 0;
        mem_busy = 0;
        redirect = 0;
        repeat (10) tick();
        check("random_progress", pops - p0 > 300, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
